// File: rtl/div_pkg.sv
// Shared types and constants for the 32-bit restoring divider.
package div_pkg;

  localparam int DATA_W    = 32;
  localparam int CNT_W     = 6;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on the {rem, quo} pair.
module div_step
  import div_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted_s;
  logic [DATA_W:0] trial_s;

  // Shift in the next dividend bit and keep the difference when it does not borrow.
  always_comb begin
    shifted_s = {rem_i, quo_i[DATA_W-1]};
    trial_s   = shifted_s - {1'b0, divisor_i};
    if (!trial_s[DATA_W]) begin
      rem_o = trial_s[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o = shifted_s[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed 32-bit divider: lo_out = quotient, hi_out = remainder.
// Define DIV_UNSIGNED_EN to add the is_unsigned port for DIVU semantics.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
  input  logic              is_unsigned,
`endif
  output logic              busy,
  output logic              done,
  output logic              dzero,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  import div_pkg::*;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_W-1:0]      rem_q, quo_q, dvs_q;
  logic [DATA_W-1:0]      rem_d, quo_d;
  logic [DATA_W-1:0]      hi_q, lo_q;
  logic                   neg_quo_q, neg_rem_q;
  logic                   busy_q, done_q, dzero_q;

  logic                   signed_mode_s;
  logic                   dvd_neg_s, dvs_neg_s;
  logic [DATA_W-1:0]      dvd_mag_s, dvs_mag_s;

  div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  // Operand magnitudes and signs as seen on the accepting edge.
  always_comb begin
    signed_mode_s = 1'b1;
`ifdef DIV_UNSIGNED_EN
    signed_mode_s = ~is_unsigned;
`endif
    dvd_neg_s = signed_mode_s & dividend[DATA_W-1];
    dvs_neg_s = signed_mode_s & divisor[DATA_W-1];
    dvd_mag_s = dvd_neg_s ? twos_neg(dividend) : dividend;
    dvs_mag_s = dvs_neg_s ? twos_neg(divisor) : divisor;
  end

  // Control FSM with registered status and results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dzero_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      dzero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              done_q  <= 1'b1;
              dzero_q <= 1'b1;
            end else begin
              rem_q     <= '0;
              quo_q     <= dvd_mag_s;
              dvs_q     <= dvs_mag_s;
              neg_quo_q <= dvd_neg_s ^ dvs_neg_s;
              neg_rem_q <= dvd_neg_s;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          lo_q    <= neg_quo_q ? twos_neg(quo_q) : quo_q;
          hi_q    <= neg_rem_q ? twos_neg(rem_q) : rem_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign dzero  = dzero_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at start, checked on done.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
`ifdef DIV_UNSIGNED_EN
  logic        is_unsigned = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic        dzero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  div_unit #(.DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .busy        (busy),
    .done        (done),
    .dzero       (dzero),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Result monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("lo_out", lo_out, e.lo);
        check("hi_out", hi_out, e.hi);
        check("dzero", 32'(dzero), 32'(e.dz));
      end
    end
  end

  // Issue one division; poke >= 0 re-raises start with new operands at that cycle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input int poke);
    int   n;
    int   busy_bad;
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (b == 32'd0) begin
      e.lo = last_lo; e.hi = last_hi; e.dz = 1'b1;
    end else begin
      e.lo = elo; e.hi = ehi; e.dz = 1'b0;
      last_lo = elo; last_hi = ehi;
    end
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    n        = 0;
    busy_bad = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) busy_bad++;
      if (n == poke) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= 100) check("timeout", 32'd1, 32'd0);
    check("latency", 32'(n), (b == 32'd0) ? 32'd0 : 32'd33);
    check("busy_during_run", 32'(busy_bad), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", {30'd0, done, dzero}, 32'd0);
  endtask

  initial begin
    int          sa;
    int          sb;
    logic [31:0] ra;
    logic [31:0] rb;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dzero", 32'(dzero), 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    reset = 1'b0;

    run_div(32'd100, 32'd7, 32'd14, 32'd2, -1);
    run_div(32'd5, 32'd0, 32'd0, 32'd0, -1);
    check("dz_hold_hi", hi_out, 32'd2);
    check("dz_hold_lo", lo_out, 32'd14);
    run_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
    run_div(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, -1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, -1);
    run_div(32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, -1);
    run_div(32'd1000, 32'd10, 32'd100, 32'd0, 4);

    // Reset in the middle of a run discards it and clears the results.
    @(negedge clk);
    dividend = 32'd20;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_hi", hi_out, 32'd0);
    check("mid_rst_lo", lo_out, 32'd0);
    reset   = 1'b0;
    last_hi = 32'd0;
    last_lo = 32'd0;
    repeat (40) @(posedge clk);
    run_div(32'd9, 32'd3, 32'd3, 32'd0, -1);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) rb = rb >> 20;
      if (rb == 32'd0) rb = 32'd1;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      sa = ra;
      sb = rb;
      run_div(ra, rb, 32'(sa / sb), 32'(sa % sb), -1);
    end

`ifdef DIV_UNSIGNED_EN
    is_unsigned = 1'b1;
    run_div(32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, -1);
    is_unsigned = 1'b0;
    run_div(32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, -1);
`endif

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
